sys_seq: RTL and testbench

SYS_SEQ -- requirements
Module: sys_seq

---
 rtl/sys_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_sys_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_seq.sv
// -----------------------------------------------------------------------------
// sys_seq -- job sequencer for an H x W weight-stationary systolic array.
//
// A job is accepted from IDLE on start. The sequencer then loads H weight rows
// (LOAD, ctrl_out=1) and streams num_cols activation columns (COMPUTE,
// ctrl_out=0). It waits H+W-2 cycles while the last partial sums ripple out of
// the array (DRAIN), pulses done for one cycle (DONE) and returns to IDLE.
// A job with num_cols=0 goes from LOAD straight to DONE. All outputs are
// decoded from the registered state and counters only.
//
// Parameters
//   H   array height, weight rows per job
//   W   array width, sets the drain length together with H
//   CW  width of num_cols
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   synchronous reset, active low
//   start        in   job request, sampled only in IDLE
//   num_cols     in   activation columns in the job, latched on acceptance
//   wt_valid     in   weight row available
//   wt_ready     out  sequencer accepts a weight row (LOAD)
//   act_valid    in   activation column available
//   act_ready    out  sequencer accepts an activation column (COMPUTE)
//   ctrl_out     out  array mode, 1 = weight load, 0 = partial-sum compute
//   row_cnt      out  index of the next weight row to load
//   busy         out  high in every state except IDLE
//   done         out  one-cycle job-complete pulse
//   perf_cycles  out  (only with SYS_SEQ_PERF_CNT_EN) job cycle count
//
// Build option
//   SYS_SEQ_PERF_CNT_EN  when defined, adds the 32-bit perf_cycles output.
// -----------------------------------------------------------------------------
module sys_seq #(
   parameter int H  = 32,
   parameter int W  = 32,
   parameter int CW = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [CW-1:0]                       num_cols,
   input  logic                                wt_valid,
   output logic                                wt_ready,
   input  logic                                act_valid,
   output logic                                act_ready,
   output logic                                ctrl_out,
   output logic [((H > 1) ? $clog2(H) : 1)-1:0] row_cnt,
   output logic                                busy,
   output logic                                done
`ifdef SYS_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]                         perf_cycles
`endif
);

   // Row counter width; a 1-row array still needs a 1-bit counter.
   localparam int RW        = (H > 1) ? $clog2(H) : 1;
   // Cycles the partial sums need to leave the array after the last column.
   localparam int DRAIN_LEN = H + W - 2;
   // Drain counter runs 0 .. DRAIN_LEN-1.
   localparam int DW        = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

   localparam logic [RW-1:0] ROW_LAST   = RW'(H - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_LEN > 0) ? (DRAIN_LEN - 1) : 0);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_COMPUTE = 3'd2,
      S_DRAIN   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   row_q,   row_d;
   logic [CW-1:0]   col_q,   col_d;
   logic [CW-1:0]   ncols_q, ncols_d;
   logic [DW-1:0]   drain_q, drain_d;

   // One extra bit so the compare against num_cols = 2^CW-1 cannot wrap.
   logic [CW:0]     col_next;

   assign col_next = {1'b0, col_q} + (CW + 1)'(1);

   // ------------------------------------------------------------------------
   // State and counter registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         ncols_q <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         ncols_q <= ncols_d;
         drain_q <= drain_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and counter logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      ncols_d = ncols_q;
      drain_d = drain_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               ncols_d = num_cols;
               row_d   = '0;
               col_d   = '0;
               drain_d = '0;
            end
         end

         // wt_ready is high for the whole of LOAD, so wt_valid alone marks a beat.
         S_LOAD: begin
            if (wt_valid) begin
               if (row_q == ROW_LAST) begin
                  row_d   = '0;
                  state_d = (ncols_q != '0) ? S_COMPUTE : S_DONE;
               end else begin
                  row_d = row_q + RW'(1);
               end
            end
         end

         // act_ready is high for the whole of COMPUTE.
         S_COMPUTE: begin
            if (act_valid) begin
               if (col_next == {1'b0, ncols_q}) begin
                  col_d   = '0;
                  // A degenerate 1x1 array has nothing to drain.
                  state_d = (DRAIN_LEN == 0) ? S_DONE : S_DRAIN;
               end else begin
                  col_d = col_next[CW-1:0];
               end
            end
         end

         S_DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               drain_d = '0;
               state_d = S_DONE;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end

         // start is deliberately not looked at here: a new job needs IDLE.
         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Moore output decode
   // ------------------------------------------------------------------------
   always_comb begin
      wt_ready  = 1'b0;
      act_ready = 1'b0;
      ctrl_out  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      row_cnt   = row_q;

      unique case (state_q)
         S_LOAD: begin
            wt_ready = 1'b1;
            ctrl_out = 1'b1;
            busy     = 1'b1;
         end
         S_COMPUTE: begin
            act_ready = 1'b1;
            busy      = 1'b1;
         end
         S_DRAIN: begin
            busy = 1'b1;
         end
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

`ifdef SYS_SEQ_PERF_CNT_EN
   // ------------------------------------------------------------------------
   // Job cycle counter
   //
   // In any busy cycle the value is the number of cycles from the start cycle
   // through the current cycle inclusive, so in the done cycle it equals the
   // full job length. Acceptance therefore restarts the count at 2 (the start
   // cycle plus the first LOAD cycle). It stops advancing on leaving DONE and
   // holds in IDLE until the next job is accepted.
   // ------------------------------------------------------------------------
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if ((state_q == S_IDLE) && start) begin
         perf_d = 32'd2;
      end else if ((state_q != S_IDLE) && (state_d != S_IDLE)) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_sys_seq.sv
// -----------------------------------------------------------------------------
// tb_sys_seq -- scoreboard bench for sys_seq with H=W=4, CW=8.
//
// Stimulus pushes the expected weight-row indices and a per-job record
// (rows, compute cycles, drain cycles, start-to-done length) into queues.
// A monitor on the falling edge pops row indices on every weight beat and
// pops a job record on every done pulse.
// -----------------------------------------------------------------------------
module tb_sys_seq;

   localparam int H  = 4;
   localparam int W  = 4;
   localparam int CW = 8;

   logic          clk       = 1'b0;
   logic          rst       = 1'b0;
   logic          start     = 1'b0;
   logic [CW-1:0] num_cols  = '0;
   logic          wt_valid  = 1'b0;
   logic          act_valid = 1'b0;
   logic          wt_ready;
   logic          act_ready;
   logic          ctrl_out;
   logic [1:0]    row_cnt;
   logic          busy;
   logic          done;
`ifdef SYS_SEQ_PERF_CNT_EN
   logic [31:0]   perf_cycles;
`endif

   sys_seq #(.H(H), .W(W), .CW(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .num_cols    (num_cols),
      .wt_valid    (wt_valid),
      .wt_ready    (wt_ready),
      .act_valid   (act_valid),
      .act_ready   (act_ready),
      .ctrl_out    (ctrl_out),
      .row_cnt     (row_cnt),
      .busy        (busy),
      .done        (done)
`ifdef SYS_SEQ_PERF_CNT_EN
      ,
      .perf_cycles (perf_cycles)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int rows;
      int acts;
      int drain;
      int len;
   } job_t;

   job_t job_q[$];
   int   row_q[$];

   // ------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------
   int   cyc       = 0;
   int   start_cyc = 0;
   int   rows_seen = 0;
   int   act_cyc   = 0;
   int   drain_cyc = 0;
   job_t mj;

   always @(negedge clk) begin
      cyc++;
      check("ready_exclusive", int'(wt_ready && act_ready), 0);
      if (!rst) begin
         rows_seen = 0;
         act_cyc   = 0;
         drain_cyc = 0;
      end else begin
         if (!busy && start) start_cyc = cyc;
         if (wt_ready) begin
            check("ctrl_in_load", int'(ctrl_out), 1);
            if (wt_valid) begin
               if (row_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL row_unexpected: weight beat at row_cnt=%0d, none expected", row_cnt);
               end else begin
                  check("row_cnt_at_beat", int'(row_cnt), row_q.pop_front());
               end
               rows_seen++;
            end
         end
         if (act_ready) begin
            check("ctrl_in_compute", int'(ctrl_out), 0);
            act_cyc++;
         end
         if (busy && !wt_ready && !act_ready && !done) drain_cyc++;
         if (done) begin
            if (job_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL done_unexpected: done=1 at cycle %0d, no job expected", cyc);
            end else begin
               mj = job_q.pop_front();
               check("job_rows",  rows_seen,             mj.rows);
               check("job_acts",  act_cyc,               mj.acts);
               check("job_drain", drain_cyc,             mj.drain);
               check("job_len",   cyc - start_cyc + 1,   mj.len);
            end
            rows_seen = 0;
            act_cyc   = 0;
            drain_cyc = 0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_rows();
      for (int r = 0; r < H; r++) row_q.push_back(r);
   endtask

   task automatic push_job(input int ncols, input int drain, input int len);
      job_t j;
      j.rows  = H;
      j.acts  = ncols;
      j.drain = drain;
      j.len   = len;
      push_rows();
      job_q.push_back(j);
   endtask

   task automatic wait_done(input string name, input int limit);
      int k;
      k = 0;
      while (!done && k < limit) begin
         tick();
         k++;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: done not seen within %0d cycles", name, limit);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wt_ready"},  int'(wt_ready),  0);
      check({tag, "_act_ready"}, int'(act_ready), 0);
      check({tag, "_ctrl_out"},  int'(ctrl_out),  0);
      check({tag, "_row_cnt"},   int'(row_cnt),   0);
      check({tag, "_busy"},      int'(busy),      0);
      check({tag, "_done"},      int'(done),      0);
   endtask

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   initial begin
      int k;

      repeat (3) tick();
      check_all_zero("reset");
`ifdef SYS_SEQ_PERF_CNT_EN
      check("reset_perf", int'(perf_cycles), 0);
`endif
      rst = 1'b1;
      tick();

      // Basic job: 4 rows, 3 columns, 6 drain cycles, 15 cycles start..done.
      num_cols  = 8'd3;
      wt_valid  = 1'b1;
      act_valid = 1'b1;
      push_job(3, 6, 15);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("first_load_wt_ready", int'(wt_ready), 1);
      check("first_load_row_cnt",  int'(row_cnt),  0);
      wait_done("basic", 100);
`ifdef SYS_SEQ_PERF_CNT_EN
      check("perf_at_done", int'(perf_cycles), 15);
      repeat (3) tick();
      check("perf_held_idle", int'(perf_cycles), 15);
`endif
      tick();
      check("idle_after_basic", int'(busy), 0);

      // Toggling weight valid: beats in LOAD cycles 1,3,5,7 -> LOAD lasts 7.
      push_job(3, 6, 18);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         wt_valid = ~wt_valid;
         check("load_hold_wt_ready", int'(wt_ready), 1);
         check("load_hold_ctrl",     int'(ctrl_out), 1);
      end
      wait_done("toggle", 100);
      tick();

      // Zero columns: LOAD goes straight to DONE, 1+4+1 = 6 cycles.
      num_cols = 8'd0;
      push_job(0, 0, 6);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("zero_cols", 100);
      tick();
      check("zero_cols_single_done", int'(done), 0);
      tick();

      // Abort during COMPUTE, then restart in the first cycle after reset.
      num_cols = 8'd3;
      push_rows();
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (!act_ready && k < 50) begin
         tick();
         k++;
      end
      check("abort_reached_compute", int'(act_ready), 1);
      rst = 1'b0;
      tick();
      check_all_zero("abort");
      rst   = 1'b1;
      start = 1'b1;
      push_job(3, 6, 15);
      tick();
      start = 1'b0;
      wait_done("restart", 100);
      tick();

      // start held high across two jobs: second one only from IDLE.
      num_cols = 8'd2;
      push_job(2, 6, 14);
      push_job(2, 6, 14);
      start = 1'b1;
      wait_done("held_1", 100);
      tick();
      check("held_idle_gap", int'(busy), 0);
      wait_done("held_2", 100);
      start = 1'b0;
`ifdef SYS_SEQ_PERF_CNT_EN
      check("perf_held_job", int'(perf_cycles), 14);
`endif
      repeat (3) tick();
      check("held_no_third_job", int'(busy), 0);

      check("rows_left", row_q.size(), 0);
      check("jobs_left", job_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
